fifo_rd_axis_master: RTL

//  Read-domain consumer of the async FIFO read side. Issues read requests to the FIFO read controller,

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_skid_buf.sv | 59 +++++
 rtl/fifo_rd_axis_master.sv | 84 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg: shared types and sizes for the FIFO read-side stream path. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int PTR_WIDTH  = 1;
  localparam int SKID_DEPTH = 2;

  typedef logic [DATA_WIDTH-1:0] fifo_data_t;
  typedef logic [1:0]            occ_t;
endpackage

`default_nettype wire

// File: rtl/fifo_skid_buf.sv
// ---------------------------------------------------------------------------
// fifo_skid_buf: 2-entry register FIFO with synchronous clear. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  r_clk,
  input  logic                  rresetn,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output occ_t                  occupancy,
  output logic                  overflow
);

  logic [DATA_WIDTH-1:0] mem [SKID_DEPTH];
  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  occ_t                  count;
  logic                  wr_ok;
  logic                  rd_ok;

  // A push into a full buffer is only legal when the same cycle pops
  assign wr_ok    = push & ((count < occ_t'(SKID_DEPTH)) | pop);
  assign rd_ok    = pop & (count != '0);
  assign overflow = push & ~wr_ok;

  always_ff @(posedge r_clk or negedge rresetn) begin
    if (!rresetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < SKID_DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) begin
        mem[tail] <= din;
        tail      <= tail + 1'b1;
      end
      if (rd_ok) head <= head + 1'b1;
      count <= count + occ_t'(wr_ok) - occ_t'(rd_ok);
    end
  end

  assign dout      = mem[head];
  assign occupancy = count;

endmodule

`default_nettype wire

// File: rtl/fifo_rd_axis_master.sv
// ---------------------------------------------------------------------------
// fifo_rd_axis_master: FIFO read side to AXI4-Stream master with tlast framing. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_rd_axis_master
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 16,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  r_clk,
  input  logic                  rresetn,
  input  logic                  flush,
  input  logic                  fifo_empty,
  output logic                  rd_req,
  input  logic                  rd_acc,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output occ_t                  occupancy,
  output logic                  burst_done
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BURST_LEN - 1);

  logic                 running;
  logic                 inflight;
  logic                 pop;
  logic                 push;
  logic                 overflow;
  logic [2:0]           used;
  logic [CNT_WIDTH-1:0] beat_cnt;

  fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .r_clk     (r_clk),
    .rresetn   (rresetn),
    .clear     (flush),
    .push      (push),
    .pop       (pop),
    .din       (fifo_rdata),
    .dout      (m_axis_tdata),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  assign pop           = m_axis_tvalid & m_axis_tready;
  assign push          = inflight & ~flush;
  assign m_axis_tvalid = (occupancy != '0);
  assign m_axis_tlast  = m_axis_tvalid & (beat_cnt == LAST_CNT);

  // Credit check counts the in-flight word; a same-cycle pop frees a slot
  assign used   = 3'(occupancy) + 3'(inflight);
  assign rd_req = running & ~fifo_empty & ~flush & (used < (3'd2 + 3'(pop)));

  always_ff @(posedge r_clk or negedge rresetn) begin
    if (!rresetn) begin
      running    <= 1'b0;
      inflight   <= 1'b0;
      beat_cnt   <= '0;
      burst_done <= 1'b0;
    end else begin
      running    <= 1'b1;
      inflight   <= rd_acc & ~flush;
      burst_done <= ~flush & pop & m_axis_tlast;
      if (flush)
        beat_cnt <= '0;
      else if (pop)
        beat_cnt <= (beat_cnt == LAST_CNT) ? '0 : beat_cnt + 1'b1;
    end
  end

  a_no_overflow: assert property (@(posedge r_clk) disable iff (!rresetn) !overflow);
  a_capacity:    assert property (@(posedge r_clk) disable iff (!rresetn) used <= 3'd2);
  a_acc_has_req: assert property (@(posedge r_clk) disable iff (!rresetn) rd_acc |-> rd_req);

endmodule

`default_nettype wire
